instruction_sequencer: RTL and testbench

//  Sequential front end that drives the SAP1 instruction decoder. Holds the instruction

---
 rtl/instruction_sequencer_pkg.sv | 18 +
 rtl/sap1_step_counter.sv | 54 +++++
 rtl/instruction_sequencer.sv | 94 +++++++++
 tb/tb_instruction_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared control-word definitions for the SAP1 sequencer/decoder pair.
// Control bits are always extracted with these masks, never with literal indices.
package instruction_sequencer_pkg;

    localparam int CONTROL_WORD_WIDTH = 16;

    localparam logic [CONTROL_WORD_WIDTH-1:0] c_HLT = 16'h8000;
    localparam logic [CONTROL_WORD_WIDTH-1:0] c_IO  = 16'h0800;
    localparam logic [CONTROL_WORD_WIDTH-1:0] c_II  = 16'h0400;
    localparam logic [CONTROL_WORD_WIDTH-1:0] c_EL  = 16'h0002;
    localparam logic [CONTROL_WORD_WIDTH-1:0] c_ADV = 16'h0001;

    function automatic logic cw_bit(input logic [CONTROL_WORD_WIDTH-1:0] cw,
                                    input logic [CONTROL_WORD_WIDTH-1:0] mask);
        return |(cw & mask);
    endfunction

endpackage

// File: rtl/sap1_step_counter.sv
// Microstep counter: step register, halt latch, wrap pulse and the HLT > ADV > wrap priority.
// o_retire flags an accepted c_ADV so the parent can count completed instructions.
module sap1_step_counter #(
    parameter int INSTRUCTION_STEPS = 8,
    parameter int STEP_WIDTH        = $clog2(INSTRUCTION_STEPS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_adv,
    input  logic                  i_hlt,
    output logic [STEP_WIDTH-1:0] o_step,
    output logic                  o_step_wrap,
    output logic                  o_halted,
    output logic                  o_retire
);

    localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

    logic [STEP_WIDTH-1:0] r_step;
    logic                  r_wrap;
    logic                  r_halted;
    logic                  w_active;

    assign w_active = i_en && !r_halted;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_step   <= '0;
            r_wrap   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_active) begin
                if (i_hlt) begin
                    r_halted <= 1'b1;
                end else if (i_adv) begin
                    r_step <= '0;
                end else if (r_step == LAST_STEP) begin
                    r_step <= '0;
                    r_wrap <= 1'b1;
                end else begin
                    r_step <= r_step + 1'b1;
                end
            end
        end
    end

    assign o_step      = r_step;
    assign o_step_wrap = r_wrap;
    assign o_halted    = r_halted;
    assign o_retire    = w_active && i_adv && !i_hlt;

endmodule

// File: rtl/instruction_sequencer.sv
// SAP1 sequencer front end: IR, flags, retired counter and step counter feeding the decoder.
// Optional SINGLE_STEP_EN adds i_ss_mode/i_ss_pulse to gate updates on pulse rising edges.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = 4,
    parameter int OPERAND_WIDTH     = 4,
    parameter int INSTRUCTION_STEPS = 8,
    parameter int RETIRED_WIDTH     = 16,
    parameter int STEP_WIDTH        = $clog2(INSTRUCTION_STEPS)
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst_n,
    input  logic [CONTROL_WORD_WIDTH-1:0]             i_control_word,
    input  logic [INSTRUCTION_WIDTH+OPERAND_WIDTH-1:0] i_bus,
    input  logic                                      i_alu_zero,
    input  logic                                      i_alu_carry,
    input  logic                                      i_alu_odd,
`ifdef SINGLE_STEP_EN
    input  logic                                      i_ss_mode,
    input  logic                                      i_ss_pulse,
`endif
    output logic [INSTRUCTION_WIDTH-1:0]              o_instruction,
    output logic [OPERAND_WIDTH-1:0]                  o_operand,
    output logic [STEP_WIDTH-1:0]                     o_step,
    output logic                                      o_zero,
    output logic                                      o_carry,
    output logic                                      o_odd,
    output logic                                      o_halted,
    output logic                                      o_step_wrap,
    output logic [RETIRED_WIDTH-1:0]                  o_retired
);

    logic [INSTRUCTION_WIDTH+OPERAND_WIDTH-1:0] r_ir;
    logic [2:0]                                 r_flags;
    logic [RETIRED_WIDTH-1:0]                   r_retired;
    logic                                       w_gate;
    logic                                       w_active;
    logic                                       w_halted;
    logic                                       w_retire;

`ifdef SINGLE_STEP_EN
    logic r_ss_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_ss_prev <= 1'b0;
        else          r_ss_prev <= i_ss_pulse;
    end

    // A held pulse opens the gate for its first cycle only.
    assign w_gate = !i_ss_mode || (i_ss_pulse && !r_ss_prev);
`else
    assign w_gate = 1'b1;
`endif

    assign w_active = w_gate && !w_halted;

    sap1_step_counter #(
        .INSTRUCTION_STEPS(INSTRUCTION_STEPS),
        .STEP_WIDTH       (STEP_WIDTH)
    ) u_step (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (w_gate),
        .i_adv      (cw_bit(i_control_word, c_ADV)),
        .i_hlt      (cw_bit(i_control_word, c_HLT)),
        .o_step     (o_step),
        .o_step_wrap(o_step_wrap),
        .o_halted   (w_halted),
        .o_retire   (w_retire)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ir      <= '0;
            r_flags   <= '0;
            r_retired <= '0;
        end else begin
            if (w_active && cw_bit(i_control_word, c_II))
                r_ir <= i_bus;
            if (w_active && cw_bit(i_control_word, c_EL))
                r_flags <= {i_alu_zero, i_alu_carry, i_alu_odd};
            if (w_retire)
                r_retired <= r_retired + RETIRED_WIDTH'(1);
        end
    end

    assign o_instruction = r_ir[INSTRUCTION_WIDTH+OPERAND_WIDTH-1:OPERAND_WIDTH];
    assign o_operand     = r_ir[OPERAND_WIDTH-1:0];
    assign {o_zero, o_carry, o_odd} = r_flags;
    assign o_halted      = w_halted;
    assign o_retired     = r_retired;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed self-checking bench for instruction_sequencer; single-step test under SINGLE_STEP_EN.
module tb_instruction_sequencer;
    import instruction_sequencer_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [CONTROL_WORD_WIDTH-1:0] cw;
    logic [7:0]                    bus;
    logic                          az, ac, ao;
`ifdef SINGLE_STEP_EN
    logic                          ss_mode, ss_pulse;
`endif
    logic [3:0]                    instr, oper;
    logic [2:0]                    step;
    logic                          fz, fc, fo, halted, wrap;
    logic [15:0]                   retired;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instruction_sequencer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_control_word(cw),
        .i_bus         (bus),
        .i_alu_zero    (az),
        .i_alu_carry   (ac),
        .i_alu_odd     (ao),
`ifdef SINGLE_STEP_EN
        .i_ss_mode     (ss_mode),
        .i_ss_pulse    (ss_pulse),
`endif
        .o_instruction (instr),
        .o_operand     (oper),
        .o_step        (step),
        .o_zero        (fz),
        .o_carry       (fc),
        .o_odd         (fo),
        .o_halted      (halted),
        .o_step_wrap   (wrap),
        .o_retired     (retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply the current inputs across one rising edge; return at the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [CONTROL_WORD_WIDTH-1:0] c, input logic [7:0] b);
        cw = c;
        bus = b;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; cw = '0; bus = '0; az = 0; ac = 0; ao = 0;
`ifdef SINGLE_STEP_EN
        ss_mode = 0; ss_pulse = 0;
`endif
        @(negedge clk);
        cyc();
        chk("rst_step", step, 0);
        chk("rst_ir", {instr, oper}, 8'h00);
        chk("rst_flags", {fz, fc, fo}, 3'b000);
        chk("rst_halted", halted, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_retired", retired, 0);
        rst_n = 1'b1;

        // LDA: fetch, load IR at step 1, advance at step 4
        drive('0, 8'h00);    chk("lda_s1", step, 1);
        drive(c_II, 8'h1A);  chk("lda_s2", step, 2);
        chk("lda_op", instr, 4'h1);
        chk("lda_arg", oper, 4'hA);
        drive('0, 8'h55);    chk("lda_s3", step, 3);
        chk("lda_ir_hold", {instr, oper}, 8'h1A);
        drive('0, 8'h00);    chk("lda_s4", step, 4);
        drive(c_ADV, 8'h00); chk("lda_s0", step, 0);
        chk("lda_retired", retired, 1);

        // Flags load then hold while ALU inputs change
        az = 1; ac = 1; ao = 0;
        drive(c_EL, 8'h00);
        chk("el_flags", {fz, fc, fo}, 3'b110);
        az = 0; ac = 0; ao = 1;
        for (int i = 0; i < 10; i++) begin
            drive('0, 8'h00);
            chk("el_hold", {fz, fc, fo}, 3'b110);
        end
        chk("el_step", step, 3);
        drive(c_ADV, 8'h00);
        chk("el_retired", retired, 2);

        // Wrap without c_ADV
        for (int i = 0; i < 8; i++) begin
            drive('0, 8'h00);
            chk("wrap_step", step, (i + 1) % 8);
            chk("wrap_pulse", wrap, (i == 7) ? 1 : 0);
        end
        drive('0, 8'h00);
        chk("wrap_clear", wrap, 0);
        chk("wrap_step1", step, 1);
        chk("wrap_retired", retired, 2);
        drive(c_ADV, 8'h00);
        chk("wrap_adv", retired, 3);

        // Halt beats advance; halted state is frozen
        drive('0, 8'h00);
        drive('0, 8'h00);
        chk("hlt_pre", step, 2);
        drive(c_HLT | c_ADV, 8'h00);
        chk("hlt_set", halted, 1);
        chk("hlt_step", step, 2);
        chk("hlt_retired", retired, 3);
        az = 1; ac = 0; ao = 1;
        for (int i = 0; i < 20; i++) begin
            drive(c_II | c_EL | c_ADV, 8'hFF);
            chk("hlt_frozen", {halted, step, instr, oper, fz, fc, fo, wrap},
                {1'b1, 3'd2, 8'h1A, 3'b110, 1'b0});
            chk("hlt_ret_frozen", retired, 3);
        end
        rst_n = 1'b0;
        drive('0, 8'h00);
        chk("hlt_rst", {halted, step, instr, oper, fz, fc, fo, wrap, retired}, 32'h0);
        rst_n = 1'b1;

        // Reset in the middle of ADD
        drive('0, 8'h00);
        drive(c_II, 8'h2B);
        chk("add_op", {instr, oper}, 8'h2B);
        az = 0; ac = 1; ao = 1;
        drive(c_EL, 8'h00);
        chk("add_flags", {fz, fc, fo}, 3'b011);
        chk("add_s3", step, 3);
        rst_n = 1'b0;
        drive('0, 8'h00);
        rst_n = 1'b1;
        chk("add_rst_step", step, 0);
        chk("add_rst_ir", {instr, oper}, 8'h00);
        chk("add_rst_flags", {fz, fc, fo}, 3'b000);

`ifdef SINGLE_STEP_EN
        // Single-step: frozen without pulses, one step per held pulse
        drive('0, 8'h00);
        chk("ss_pre", step, 1);
        ss_mode = 1;
        for (int i = 0; i < 10; i++) begin
            drive('0, 8'h00);
            chk("ss_frozen", step, 1);
        end
        ss_pulse = 1;
        for (int i = 0; i < 5; i++) begin
            drive('0, 8'h00);
            chk("ss_held", step, 2);
        end
        ss_pulse = 0;
        drive('0, 8'h00);
        chk("ss_low", step, 2);
        ss_mode = 0;
        drive('0, 8'h00);
        chk("ss_off", step, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
